mcpu_seq: RTL and testbench
===========================

MCPU_SEQ -- requirements
Module: mcpu_seq

Interface
REQ-001 Parameter AW, default 32: width of the PC, EPC and target buses.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value after reset.
REQ-003 Parameter INT_VEC, default 32'h0000_0004: interrupt entry address.
REQ-004 Parameter EXC_VEC, default 32'h0000_0008: bus-error / illegal-instruction entry address.
REQ-005 Parameter TIMEOUT, default 15, range 1..255: maximum wait cycles for MIO_ready.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 MIO_ready  in  1  memory handshake complete for the current access.
REQ-009 INT  in  1  level-sensitive interrupt request.
REQ-010 opcode  in  6  and  funct  in  6  fields of the instruction register.
REQ-011 zero  in  1  ALU zero flag.
REQ-012 br_target  in  AW  and  j_target  in  AW  branch and jump destinations from the datapath.
REQ-013 PC_out  out  AW  current PC; EPC_out  out  AW  saved return address.
REQ-014 state  out  5  state code; MemRead, MemWrite, IorD, IRWrite, RegWrite, int_ack  out  1 each.
REQ-015 bus_err  out  1  sticky error flag; ie  out  1  interrupt enable.

Function
REQ-016 The sequencer SHALL use states IF=0, ID=1, EX=2, MEM=3, WB=4, BR=5, JMP=6, INT=7, ERR=8, and drive the code on state.
REQ-017 IF: MemRead=1, IorD=0. On MIO_ready: IRWrite=1 for that cycle, pc_cur<=PC, PC<=PC+4 (mod 2^AW), next state ID.
REQ-018 ID decodes in one cycle: 0x00 R-type, 0x08 ADDI, 0x23 LW and 0x2B SW go to EX. 0x04 BEQ goes to BR. 0x02 J goes to JMP. Opcode 0x10 with funct 0x18 (ERET) goes to EX. Any other opcode goes to ERR.
REQ-019 EX: ERET loads PC<=EPC, sets ie<=1 and goes to IF. LW and SW go to MEM. R-type and ADDI go to WB.
REQ-020 MEM: IorD=1, with MemRead=1 for LW or MemWrite=1 for SW. On MIO_ready, LW goes to WB and SW retires.
REQ-021 WB: RegWrite=1 for exactly one cycle, then the instruction retires.
REQ-022 BR: if zero=1, PC<=br_target. The instruction retires.
REQ-023 JMP: PC<=j_target. The instruction retires.
REQ-024 Retire: if INT=1 and ie=1, next state is INT; otherwise next state is IF.
REQ-025 INT (one cycle): EPC<=PC, PC<=INT_VEC, ie<=0, int_ack=1, next state IF.
REQ-026 Wait counter: clears on entry to IF or MEM and increments each cycle without MIO_ready. The cycle in which it reaches TIMEOUT without MIO_ready goes to ERR; no write strobe and no IRWrite are issued in that cycle.
REQ-027 ERR (one cycle): bus_err<=1, EPC<=pc_cur, PC<=EXC_VEC, ie<=0, next state IF. bus_err stays 1 until reset.
REQ-028 MIO_ready outside IF and MEM SHALL be ignored.
REQ-029 MIO_ready arriving in the same cycle the counter hits TIMEOUT SHALL win: the access completes normally.
REQ-030 INT is sampled only at retire. INT pulses between retire points are not latched.
REQ-031 All control outputs SHALL be combinational from state, opcode and MIO_ready, and SHALL be 0 in INT, ERR, BR and JMP.

Reset
REQ-032 Reset low SHALL asynchronously force: state=IF, PC=RESET_PC, EPC=0, pc_cur=0, ie=1, bus_err=0, wait counter=0.
REQ-033 Reset asserted mid-access SHALL abandon the access with no RegWrite or IRWrite pulse. The first fetch after release starts at RESET_PC.

Verification
REQ-034 Reset, then ADDI fetched with MIO_ready after 2 cycles: sequence IF,IF,IF,ID,EX,WB,IF. One RegWrite pulse. PC 0 -> 4.
REQ-035 BEQ at PC=0x10 with zero=1 and br_target=0x40: after BR, PC=0x40. Repeat with zero=0: PC=0x14.
REQ-036 INT=1 while an SW retires with PC=0x24 and ie=1: state INT, int_ack 1 cycle, EPC=0x24, PC=0x4, ie=0. A following ERET restores PC=0x24 and ie=1.
REQ-037 LW in MEM with MIO_ready held low and TIMEOUT=15: ERR entered after 15 waiting cycles, bus_err=1, EPC=pc_cur, PC=0x8, no RegWrite.
REQ-038 Illegal opcode 0x3F at PC=0x30: ID goes to ERR, EPC=0x30, PC=0x8.
REQ-039 reset pulsed low during the MEM wait of an SW: MemWrite drops immediately, and after release PC=RESET_PC and bus_err=0.

Source files
------------

// File: rtl/mcpu_seq.sv
// Multi-cycle CPU control sequencer: fetch/decode/execute FSM with
// memory wait timeout, single-level interrupt entry and bus-error trap.
module mcpu_seq #(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [AW-1:0] INT_VEC  = 32'h0000_0004,
    parameter logic [AW-1:0] EXC_VEC  = 32'h0000_0008,
    parameter int            TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MIO_ready,
    input  logic          INT,
    input  logic [5:0]    opcode,
    input  logic [5:0]    funct,
    input  logic          zero,
    input  logic [AW-1:0] br_target,
    input  logic [AW-1:0] j_target,
    output logic [AW-1:0] PC_out,
    output logic [AW-1:0] EPC_out,
    output logic [4:0]    state,
    output logic          MemRead,
    output logic          MemWrite,
    output logic          IorD,
    output logic          IRWrite,
    output logic          RegWrite,
    output logic          int_ack,
    output logic          bus_err,
    output logic          ie
);

    typedef enum logic [4:0] {
        S_IF  = 5'd0,
        S_ID  = 5'd1,
        S_EX  = 5'd2,
        S_MEM = 5'd3,
        S_WB  = 5'd4,
        S_BR  = 5'd5,
        S_JMP = 5'd6,
        S_INT = 5'd7,
        S_ERR = 5'd8
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t        st;
    logic [AW-1:0] pc;
    logic [AW-1:0] epc;
    logic [AW-1:0] pc_cur;
    logic [7:0]    cnt;
    logic          ie_r;
    logic          be_r;

    logic   is_lw;
    logic   is_sw;
    logic   is_eret;
    logic   is_exok;
    logic   tmo;
    state_t retire_st;

    assign is_lw   = (opcode == 6'h23);
    assign is_sw   = (opcode == 6'h2B);
    assign is_eret = (opcode == 6'h10) && (funct == 6'h18);
    assign is_exok = (opcode == 6'h00) || (opcode == 6'h08) ||
                     is_lw || is_sw || is_eret;

    // Last permitted wait cycle; a ready in this same cycle still wins.
    assign tmo       = (cnt == TO_LAST) && !MIO_ready;
    assign retire_st = (INT && ie_r) ? S_INT : S_IF;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st     <= S_IF;
            pc     <= RESET_PC;
            epc    <= '0;
            pc_cur <= '0;
            cnt    <= '0;
            ie_r   <= 1'b1;
            be_r   <= 1'b0;
        end else begin
            cnt <= '0;
            unique case (st)
                S_IF: begin
                    if (MIO_ready) begin
                        pc_cur <= pc;
                        pc     <= pc + AW'(4);
                        st     <= S_ID;
                    end else if (tmo) begin
                        st <= S_ERR;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_ID: begin
                    if (is_exok)
                        st <= S_EX;
                    else if (opcode == 6'h04)
                        st <= S_BR;
                    else if (opcode == 6'h02)
                        st <= S_JMP;
                    else
                        st <= S_ERR;
                end
                S_EX: begin
                    if (is_eret) begin
                        pc   <= epc;
                        ie_r <= 1'b1;
                        st   <= S_IF;
                    end else if (is_lw || is_sw) begin
                        st <= S_MEM;
                    end else begin
                        st <= S_WB;
                    end
                end
                S_MEM: begin
                    if (MIO_ready)
                        st <= is_lw ? S_WB : retire_st;
                    else if (tmo)
                        st <= S_ERR;
                    else
                        cnt <= cnt + 8'd1;
                end
                S_WB: st <= retire_st;
                S_BR: begin
                    if (zero)
                        pc <= br_target;
                    st <= retire_st;
                end
                S_JMP: begin
                    pc <= j_target;
                    st <= retire_st;
                end
                S_INT: begin
                    epc  <= pc;
                    pc   <= INT_VEC;
                    ie_r <= 1'b0;
                    st   <= S_IF;
                end
                S_ERR: begin
                    be_r <= 1'b1;
                    epc  <= pc_cur;
                    pc   <= EXC_VEC;
                    ie_r <= 1'b0;
                    st   <= S_IF;
                end
                default: st <= S_IF;
            endcase
        end
    end

    always_comb begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        int_ack  = 1'b0;
        unique case (1'b1)
            (st == S_IF): begin
                MemRead = 1'b1;
                IRWrite = MIO_ready;
            end
            (st == S_MEM): begin
                IorD     = 1'b1;
                MemRead  = is_lw;
                MemWrite = is_sw;
            end
            (st == S_WB):  RegWrite = 1'b1;
            (st == S_INT): int_ack  = 1'b1;
            default: ;
        endcase
    end

    assign state   = st;
    assign PC_out  = pc;
    assign EPC_out = epc;
    assign bus_err = be_r;
    assign ie      = ie_r;

endmodule

// File: tb/tb_mcpu_seq.sv
// Testbench for mcpu_seq: instruction vector table plus hand-written
// timeout, ready-wins and mid-access reset sequences.
module tb_mcpu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        MIO_ready;
    logic        INT;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] PC_out;
    logic [31:0] EPC_out;
    logic [4:0]  state;
    logic        MemRead, MemWrite, IorD, IRWrite, RegWrite, int_ack;
    logic        bus_err, ie;
    logic [5:0]  ctrl;

    mcpu_seq #(
        .AW(32), .RESET_PC(32'h0), .INT_VEC(32'h4),
        .EXC_VEC(32'h8), .TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .INT(INT),
        .opcode(opcode), .funct(funct), .zero(zero),
        .br_target(br_target), .j_target(j_target),
        .PC_out(PC_out), .EPC_out(EPC_out), .state(state),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .int_ack(int_ack),
        .bus_err(bus_err), .ie(ie)
    );

    always #5 clk = ~clk;

    assign ctrl = {MemRead, MemWrite, IorD, IRWrite, RegWrite, int_ack};

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zr;
        logic        intr;
        logic [31:0] brt;
        logic [31:0] jt;
    } drv_t;

    // seq holds expected states as nibbles, first cycle in the top nibble
    typedef struct packed {
        drv_t        d;
        logic [31:0] seq;
        logic [3:0]  len;
        logic [7:0]  rdy;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        ie;
        logic        be;
    } vec_t;

    vec_t       vt [12];
    drv_t       cur;
    logic [9:0] exp_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] exp_ctrl(input logic [3:0] s,
                                            input logic [5:0] op,
                                            input logic r);
        case (s)
            4'd0:    return {1'b1, 1'b0, 1'b0, r, 1'b0, 1'b0};
            4'd3:    return {op == 6'h23, op == 6'h2B, 1'b1, 3'b000};
            4'd4:    return 6'b000010;
            4'd7:    return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic step(input logic [3:0] es, input logic r);
        logic [9:0] e;
        @(negedge clk);
        opcode    = cur.op;
        funct     = cur.fn;
        zero      = cur.zr;
        INT       = cur.intr;
        br_target = cur.brt;
        j_target  = cur.jt;
        MIO_ready = r;
        exp_q.push_back({es, exp_ctrl(es, cur.op, r)});
        #1;
        e = exp_q.pop_front();
        chk($sformatf("state@%0t", $time), {27'd0, state}, {28'd0, e[9:6]});
        chk($sformatf("ctrl@%0t", $time), {26'd0, ctrl}, {26'd0, e[5:0]});
    endtask

    task automatic post(input string nm, input logic [31:0] pc,
                        input logic [31:0] epc, input logic ie_e,
                        input logic be_e);
        @(posedge clk);
        #1;
        chk({nm, " next"}, {27'd0, state}, 32'd0);
        chk({nm, " pc"}, PC_out, pc);
        chk({nm, " epc"}, EPC_out, epc);
        chk({nm, " ie"}, {31'd0, ie}, {31'd0, ie_e});
        chk({nm, " be"}, {31'd0, bus_err}, {31'd0, be_e});
    endtask

    initial begin
        vt[0]  = '{'{6'h08, 6'h00, 1'b0, 1'b0, 32'h40, 32'h0},
                   32'h00012400, 4'd6, 8'b0011_1100,
                   32'h04, 32'h00, 1'b1, 1'b0};
        vt[1]  = '{'{6'h00, 6'h20, 1'b0, 1'b0, 32'h40, 32'h0},
                   32'h01240000, 4'd4, 8'b0000_0001,
                   32'h08, 32'h00, 1'b1, 1'b0};
        vt[2]  = '{'{6'h23, 6'h00, 1'b0, 1'b0, 32'h40, 32'h0},
                   32'h00123334, 4'd8, 8'b0100_0010,
                   32'h0C, 32'h00, 1'b1, 1'b0};
        vt[3]  = '{'{6'h2B, 6'h00, 1'b0, 1'b0, 32'h40, 32'h0},
                   32'h01230000, 4'd4, 8'b0000_1001,
                   32'h10, 32'h00, 1'b1, 1'b0};
        vt[4]  = '{'{6'h04, 6'h00, 1'b1, 1'b0, 32'h40, 32'h0},
                   32'h01500000, 4'd3, 8'b0000_0001,
                   32'h40, 32'h00, 1'b1, 1'b0};
        vt[5]  = '{'{6'h02, 6'h00, 1'b0, 1'b0, 32'h40, 32'h10},
                   32'h01600000, 4'd3, 8'b0000_0001,
                   32'h10, 32'h00, 1'b1, 1'b0};
        vt[6]  = '{'{6'h04, 6'h00, 1'b0, 1'b0, 32'h40, 32'h0},
                   32'h01500000, 4'd3, 8'b0000_0001,
                   32'h14, 32'h00, 1'b1, 1'b0};
        vt[7]  = '{'{6'h02, 6'h00, 1'b0, 1'b0, 32'h40, 32'h20},
                   32'h01600000, 4'd3, 8'b0000_0001,
                   32'h20, 32'h00, 1'b1, 1'b0};
        vt[8]  = '{'{6'h2B, 6'h00, 1'b0, 1'b1, 32'h40, 32'h0},
                   32'h01237000, 4'd5, 8'b0000_1001,
                   32'h04, 32'h24, 1'b0, 1'b0};
        vt[9]  = '{'{6'h10, 6'h18, 1'b0, 1'b0, 32'h40, 32'h0},
                   32'h01200000, 4'd3, 8'b0000_0001,
                   32'h24, 32'h24, 1'b1, 1'b0};
        vt[10] = '{'{6'h02, 6'h00, 1'b0, 1'b0, 32'h40, 32'h30},
                   32'h01600000, 4'd3, 8'b0000_0001,
                   32'h30, 32'h24, 1'b1, 1'b0};
        vt[11] = '{'{6'h3F, 6'h00, 1'b0, 1'b0, 32'h40, 32'h0},
                   32'h01800000, 4'd3, 8'b0000_0001,
                   32'h08, 32'h30, 1'b0, 1'b1};

        reset = 1'b0;
        MIO_ready = 1'b0;
        INT = 1'b0;
        opcode = 6'h0;
        funct = 6'h0;
        zero = 1'b0;
        br_target = 32'h0;
        j_target = 32'h0;
        cur = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst state", {27'd0, state}, 32'd0);
        chk("rst pc", PC_out, 32'h0);
        chk("rst epc", EPC_out, 32'h0);
        chk("rst ie", {31'd0, ie}, 32'd1);
        chk("rst be", {31'd0, bus_err}, 32'd0);
        chk("rst ctrl", {26'd0, ctrl}, 32'h20);
        #1 reset = 1'b1;

        for (int v = 0; v < 12; v++) begin
            cur = vt[v].d;
            for (int i = 0; i < int'(vt[v].len); i++)
                step(vt[v].seq[28-4*i +: 4], vt[v].rdy[i]);
            post($sformatf("v%0d", v), vt[v].pc, vt[v].epc,
                 vt[v].ie, vt[v].be);
        end

        // LW: ready arrives on the final permitted wait cycle
        cur = '{6'h23, 6'h00, 1'b0, 1'b0, 32'h0, 32'h0};
        step(4'd0, 1'b1);
        step(4'd1, 1'b0);
        step(4'd2, 1'b0);
        for (int i = 0; i < 14; i++) step(4'd3, 1'b0);
        step(4'd3, 1'b1);
        step(4'd4, 1'b0);
        post("lw_win", 32'h0C, 32'h30, 1'b0, 1'b1);

        // LW: memory never answers
        step(4'd0, 1'b1);
        step(4'd1, 1'b0);
        step(4'd2, 1'b0);
        for (int i = 0; i < 15; i++) step(4'd3, 1'b0);
        step(4'd8, 1'b0);
        post("lw_tmo", 32'h08, 32'h0C, 1'b0, 1'b1);

        // SW: reset in the middle of the MEM wait
        cur = '{6'h2B, 6'h00, 1'b0, 1'b0, 32'h0, 32'h0};
        step(4'd0, 1'b1);
        step(4'd1, 1'b0);
        step(4'd2, 1'b0);
        step(4'd3, 1'b0);
        step(4'd3, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("mrst state", {27'd0, state}, 32'd0);
        chk("mrst memwrite", {31'd0, MemWrite}, 32'd0);
        chk("mrst pc", PC_out, 32'h0);
        chk("mrst be", {31'd0, bus_err}, 32'd0);
        chk("mrst epc", EPC_out, 32'h0);
        chk("mrst ie", {31'd0, ie}, 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        cur = '{6'h08, 6'h00, 1'b0, 1'b0, 32'h0, 32'h0};
        step(4'd0, 1'b1);
        step(4'd1, 1'b0);
        step(4'd2, 1'b0);
        step(4'd4, 1'b0);
        post("after_rst", 32'h04, 32'h00, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
